// File: rtl/fft_input_loader.sv
// Frame buffer ahead of the 64-point FFT: fills N samples, then replays them bit-reversed (FFT_LOADER_BITREV_EN) or in natural order.
// Latency: first sample out 2 cycles after the last accept; backpressure: in_ready low from frame full until fft_finished.
module fft_input_loader #(
  parameter int DATA_W = 16,
  parameter int LOG2N  = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic [LOG2N-1:0]  out_index,
  output logic              start,
  input  logic              fft_finished,
  output logic              busy,
  output logic [7:0]        frame_count
);

  localparam int N = 1 << LOG2N;

  typedef enum logic [1:0] {
    S_FILL,
    S_DRAIN,
    S_WAIT
  } state_t;

  state_t state, state_nxt;

  logic [2*DATA_W-1:0] mem [N];
  logic [LOG2N-1:0]    wr_ptr;
  logic [LOG2N-1:0]    rd_ptr;
  logic [LOG2N-1:0]    rd_addr;
  logic                accept;
  logic                draining;
  logic                frame_done;

`ifdef FFT_LOADER_BITREV_EN
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = a[LOG2N-1-i];
    end
    return r;
  endfunction

  assign rd_addr = bitrev(rd_ptr);
`else
  assign rd_addr = rd_ptr;
`endif

  assign accept     = in_valid && in_ready && (state == S_FILL);
  assign draining   = (state == S_DRAIN);
  assign frame_done = (state == S_WAIT) && fft_finished;
  assign busy       = (state != S_FILL);

  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL:  if (accept && (&wr_ptr)) state_nxt = S_DRAIN;
      S_DRAIN: if (&rd_ptr) state_nxt = S_WAIT;
      S_WAIT:  if (fft_finished) state_nxt = S_FILL;
      default: state_nxt = S_FILL;
    endcase
  end

  // Storage array is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clock) begin
    if (accept) begin
      mem[wr_ptr] <= {in_real, in_imag};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_FILL;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      start       <= 1'b0;
      out_index   <= '0;
      out_real    <= '0;
      out_imag    <= '0;
      frame_count <= '0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == S_FILL);
      out_valid <= draining;
      start     <= draining && (rd_ptr == '0);
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      // One read per DRAIN cycle; the registered result is the presented sample.
      if (draining) begin
        rd_ptr                 <= rd_ptr + 1'b1;
        out_index              <= rd_ptr;
        {out_real, out_imag}   <= mem[rd_addr];
      end
      if (frame_done) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule
